lfsr_nb: RTL and testbench
==========================

# lfsr_nb

Parametrised N-bit LFSR engine for the encoder/decoder datapath. It generalises the fixed 6-bit generator in three ways:

- configurable width;
- a Galois mode alongside Fibonacci;
- a multi-cycle skip-ahead ("step N") operation with a busy/done handshake.

Period measurement and lock-up detection let the host confirm a tap pattern is maximal-length before using it for keystream.

## Interface
Parameters:
- WIDTH, default 6, LFSR width in bits (≥ 3).
- CNT_W, default 8, width of the skip-ahead count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- init  in  1  load seed, taps and mode; aborts any step operation.
- start  in  WIDTH  seed value, latched on init.
- taps  in  WIDTH  feedback pattern, latched on init.
- mode  in  1  latched on init. 0 = Fibonacci, 1 = Galois.
- en  in  1  advance one state this cycle; ignored while step_busy.
- step_req  in  1  request N advances; sampled only when idle.
- step_cnt  in  CNT_W  N, sampled with step_req.
- state  out  WIDTH  current state.
- fb_bit  out  1  combinational feedback/output bit of the current state.
- lockup  out  1  combinational; 1 when state == 0.
- step_busy  out  1  step operation in progress.
- step_done  out  1  one-cycle pulse when the step completes.
- period  out  WIDTH  measured sequence period.
- period_valid  out  1  period holds a valid measurement; sticky until init.

## Operation
- Reset (rst_n = 0 at an edge) clears all registers: state, taps, mode, step_busy, step_done, remaining count, advance counter, period and period_valid all go to 0.
  - lockup therefore reads 1 after reset.
- Fibonacci advance: fb_bit = ^(state & taps); state ← {state[WIDTH-2:0], fb_bit}.
- Galois advance: fb_bit = state[WIDTH-1]; state ← {state[WIDTH-2:0], 1'b0} ^ (fb_bit ? taps : 0).
- Priority at each edge is rst_n, then init, then step engine, then en.
- init:
  - state ← start, taps/mode latched, advance counter ← 0, period ← 0, period_valid ← 0.
  - step_busy ← 0; no step_done pulse is produced.
- Step engine (states IDLE/RUN):
  - In IDLE, step_req with N > 0: RUN, remaining ← N. No advance on that edge.
  - In RUN, each edge advances once and decrements remaining. On the edge that advances with remaining == 1: IDLE, step_done ← 1.
  - step_req with N == 0 in IDLE: step_done ← 1 on that edge; state is unchanged and the engine stays in IDLE.
  - step_req and en in the same IDLE cycle: step_req wins and en is dropped.
  - en and step_req are both ignored in RUN.
- Period measurement: every advance (en or step) increments the advance counter.
  - On the first advance whose next state equals the latched seed: period ← counter + 1, period_valid ← 1.
  - period and period_valid then freeze until the next init.
  - The advance counter saturates at all-ones.
  - A zero seed in Fibonacci mode yields period = 1 on the first advance.
- Lock-up: an all-zero state stays zero in both modes; lockup stays 1. No auto-recovery, only init exits lock-up.

## Timing
- en: state updates at the same edge en is sampled; latency 1 cycle.
- step N > 0: with step_req sampled at edge k, advances occur at edges k+1 … k+N. step_busy is high from after k until after k+N. step_done is high for the one cycle after edge k+N.
- step N = 0: step_done is high for the cycle after edge k.
- step_done never coincides with step_busy.
- init during RUN takes effect at that edge. step_busy is 0 and step_done is 0 the following cycle.
- rst_n low during RUN clears everything at that edge, identically to a power-on reset.
- fb_bit and lockup are purely combinational from the registered state and taps.

## Test plan
- Fibonacci chain: WIDTH = 6, init with taps = 6'h21, start = 6'h01, mode = 0, then en for 6 cycles → state = 03, 07, 0F, 1F, 3F, 3E.
- Period: same configuration, en held → period_valid rises after the 63rd advance with period = 63; counter-based values then freeze.
- Galois chain: taps = 6'h21, start = 6'h01, mode = 1, en ×6 → state = 02, 04, 08, 10, 20, 21.
- Skip-ahead: Fibonacci from 01, step_req with step_cnt = 5.
  - step_busy is high for 5 cycles, then step_done pulses once with state = 3F.
  - en asserted during RUN has no effect.
  - step_cnt = 0 → step_done the next cycle with state unchanged.
- Abort and lock-up:
  - init mid-step → no step_done and state = new seed.
  - init with start = 0 → lockup = 1, state stays 0 under en, period = 1.
  - rst_n = 0 mid-step → all outputs 0 and lockup = 1.

Source files
------------

// File: rtl/lfsr_nb.sv
// lfsr_nb: parametrised Fibonacci/Galois LFSR with a skip-ahead step engine,
// period measurement and lock-up flag.
module lfsr_nb #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [WIDTH-1:0] start,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  input  logic             en,
  input  logic             step_req,
  input  logic [CNT_W-1:0] step_cnt,
  output logic [WIDTH-1:0] state,
  output logic             fb_bit,
  output logic             lockup,
  output logic             step_busy,
  output logic             step_done,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} step_st_e;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  step_st_e         st_p0;
  logic [WIDTH-1:0] state_p0;
  logic [WIDTH-1:0] taps_p0;
  logic [WIDTH-1:0] seed_p0;
  logic [WIDTH-1:0] adv_cnt_p0;
  logic [WIDTH-1:0] period_p0;
  logic [CNT_W-1:0] remain_p0;
  logic             mode_p0;
  logic             done_p0;
  logic             pvld_p0;
  logic             adv;
  logic [WIDTH-1:0] nxt;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + ONE_W;
  endfunction

  always_comb begin
    fb_bit = mode_p0 ? state_p0[WIDTH-1] : ^(state_p0 & taps_p0);
    if (mode_p0)
      nxt = {state_p0[WIDTH-2:0], 1'b0} ^ (fb_bit ? taps_p0 : '0);
    else
      nxt = {state_p0[WIDTH-2:0], fb_bit};
    // a pending step_req in IDLE takes the cycle, so en is dropped
    adv = (st_p0 == RUN) || (!step_req && en);
  end

  // stage p0: architectural state, step engine and period capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_p0      <= IDLE;
      state_p0   <= '0;
      taps_p0    <= '0;
      seed_p0    <= '0;
      mode_p0    <= 1'b0;
      remain_p0  <= '0;
      adv_cnt_p0 <= '0;
      period_p0  <= '0;
      pvld_p0    <= 1'b0;
      done_p0    <= 1'b0;
    end else if (init) begin
      st_p0      <= IDLE;
      state_p0   <= start;
      taps_p0    <= taps;
      seed_p0    <= start;
      mode_p0    <= mode;
      remain_p0  <= '0;
      adv_cnt_p0 <= '0;
      period_p0  <= '0;
      pvld_p0    <= 1'b0;
      done_p0    <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      if (st_p0 == RUN) begin
        remain_p0 <= remain_p0 - ONE_C;
        if (remain_p0 == ONE_C) begin
          st_p0   <= IDLE;
          done_p0 <= 1'b1;
        end
      end else if (step_req) begin
        if (step_cnt == '0) begin
          done_p0 <= 1'b1;
        end else begin
          st_p0     <= RUN;
          remain_p0 <= step_cnt;
        end
      end
      if (adv) begin
        state_p0   <= nxt;
        adv_cnt_p0 <= sat_inc(adv_cnt_p0);
        if (!pvld_p0 && (nxt == seed_p0)) begin
          period_p0 <= sat_inc(adv_cnt_p0);
          pvld_p0   <= 1'b1;
        end
      end
    end
  end

  assign state        = state_p0;
  assign lockup       = (state_p0 == '0);
  assign step_busy    = (st_p0 == RUN);
  assign step_done    = done_p0;
  assign period       = period_p0;
  assign period_valid = pvld_p0;

endmodule

// File: tb/tb_lfsr_nb.sv
// tb_lfsr_nb: scoreboard bench for lfsr_nb; a behavioural model queues the
// expected outputs per cycle and a negedge monitor compares them.
module tb_lfsr_nb;
  localparam int W  = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic [W-1:0]  start = '0;
  logic [W-1:0]  taps = '0;
  logic          mode = 1'b0;
  logic          en = 1'b0;
  logic          step_req = 1'b0;
  logic [CW-1:0] step_cnt = '0;
  logic [W-1:0]  state;
  logic          fb_bit;
  logic          lockup;
  logic          step_busy;
  logic          step_done;
  logic [W-1:0]  period;
  logic          period_valid;

  lfsr_nb #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .start(start), .taps(taps),
    .mode(mode), .en(en), .step_req(step_req), .step_cnt(step_cnt),
    .state(state), .fb_bit(fb_bit), .lockup(lockup), .step_busy(step_busy),
    .step_done(step_done), .period(period), .period_valid(period_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int fb;
    int lk;
    int busy;
    int done;
    int per;
    int pv;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int m_state = 0, m_taps = 0, m_mode = 0, m_seed = 0;
  int m_adv = 0, m_period = 0, m_pvld = 0, m_left = 0, m_done = 0;

  function automatic int next_of(int s, int t, int md);
    int v;
    v = s * 2;
    if (md == 0) begin
      v = (v % (1 << W)) | ($countones(s & t) % 2);
    end else if (v >= (1 << W)) begin
      v = (v - (1 << W)) ^ t;
    end
    return v;
  endfunction

  function automatic int fb_of(int s, int t, int md);
    return (md != 0) ? ((s >> (W - 1)) & 1) : ($countones(s & t) % 2);
  endfunction

  task automatic model_advance();
    m_state = next_of(m_state, m_taps, m_mode);
    m_adv++;
    if (m_pvld == 0 && m_state == m_seed) begin
      m_pvld   = 1;
      m_period = m_adv;
    end
  endtask

  // one clock: model the edge from the current inputs, queue the result
  task automatic tick();
    exp_t e;
    @(posedge clk);
    m_done = 0;
    if (!rst_n) begin
      m_state = 0; m_taps = 0; m_mode = 0; m_seed = 0;
      m_adv = 0; m_period = 0; m_pvld = 0; m_left = 0;
    end else if (init) begin
      m_state = int'(start); m_taps = int'(taps); m_mode = int'(mode);
      m_seed = int'(start); m_adv = 0; m_period = 0; m_pvld = 0; m_left = 0;
    end else if (m_left > 0) begin
      model_advance();
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (step_req) begin
      if (step_cnt == 0) m_done = 1;
      else m_left = int'(step_cnt);
    end else if (en) begin
      model_advance();
    end
    e.st   = m_state;
    e.fb   = fb_of(m_state, m_taps, m_mode);
    e.lk   = (m_state == 0) ? 1 : 0;
    e.busy = (m_left > 0) ? 1 : 0;
    e.done = m_done;
    e.per  = m_period;
    e.pv   = m_pvld;
    sb.push_back(e);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("state", int'(state), e.st);
        chk("fb_bit", int'(fb_bit), e.fb);
        chk("lockup", int'(lockup), e.lk);
        chk("step_busy", int'(step_busy), e.busy);
        chk("step_done", int'(step_done), e.done);
        chk("period", int'(period), e.per);
        chk("period_valid", int'(period_valid), e.pv);
      end
    end
  end

  task automatic do_init(input int s, input int t, input int md);
    init = 1'b1; start = W'(s); taps = W'(t); mode = md[0];
    tick();
    init = 1'b0;
  endtask

  task automatic do_en(input int n);
    en = 1'b1;
    repeat (n) tick();
    en = 1'b0;
  endtask

  task automatic do_step(input int n, input bit en_during);
    step_req = 1'b1; step_cnt = CW'(n);
    tick();
    step_req = 1'b0;
    en = en_during;
    repeat (n + 1) tick();
    en = 1'b0;
  endtask

  initial begin : stim
    int drain;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Fibonacci chain and full-period measurement
    do_init(6'h01, 6'h21, 0);
    do_en(6);
    do_en(70);

    // Galois chain
    do_init(6'h01, 6'h21, 1);
    do_en(6);
    do_en(66);

    // skip-ahead with en held during RUN, then zero-length step
    do_init(6'h01, 6'h21, 0);
    do_step(5, 1'b1);
    do_step(0, 1'b0);
    step_req = 1'b1; en = 1'b1; step_cnt = CW'(3);
    tick();
    step_req = 1'b0; en = 1'b0;
    repeat (4) tick();

    // init aborts a running step
    step_req = 1'b1; step_cnt = CW'(10);
    tick();
    step_req = 1'b0;
    repeat (3) tick();
    do_init(6'h15, 6'h21, 0);
    repeat (3) tick();

    // zero seed locks up in both modes
    do_init(0, 6'h21, 0);
    do_en(4);
    do_init(0, 6'h30, 1);
    do_en(3);

    // reset during RUN
    do_init(6'h2A, 6'h21, 1);
    step_req = 1'b1; step_cnt = CW'(8);
    tick();
    step_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized mix of init, en, step and reset
    do_init(6'h01, 6'h21, 0);
    for (int i = 0; i < 600; i++) begin
      init = 1'b0; step_req = 1'b0; rst_n = 1'b1;
      if ($urandom_range(0, 49) == 0) begin
        init  = 1'b1;
        start = W'($urandom_range(0, 63));
        taps  = W'($urandom_range(0, 63)) | 6'h20;
        mode  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      en = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        step_req = 1'b1;
        step_cnt = CW'($urandom_range(0, 9));
      end
      tick();
    end
    init = 1'b0; step_req = 1'b0; en = 1'b0; rst_n = 1'b1;

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    #1;
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
